line_derotator: RTL and testbench
=================================

Name: line_derotator

Overview:
- Descrambler paired with line_rotator. Takes the scrambled 10-bit BT.656 stream plus H/V from sync_parser. Undoes the per-line cyclic rotation of active video samples and emits a legal BT.656 stream.
- Sits between the decoder-side sync_parser and the video output path.
- Uses ping-pong line buffers, so active content has exactly one line of latency. Timing reference and blanking words pass through with 1-cycle latency.

Parameters:
- ACTIVE_LEN, 1440: active 10-bit words per line (720 px, 4:2:2 multiplexed).
- CUT_STEP, 4: words per raw cut unit. Keeps Cb-Y-Cr-Y quad alignment. Requires 255*CUT_STEP < ACTIVE_LEN.
- ADDR_W, 11: buffer address width, ≥ clog2(ACTIVE_LEN).

Ports:
- clk  in  1  system clock (27 MHz word clock).
- reset_n  in  1  asynchronous active-low reset.
- data_in  in  10  scrambled BT.656 word.
- raw_cut_position  in  8  cut value for the line whose active region is currently starting.
- V  in  1  vertical blanking flag, aligned with data_in.
- H  in  1  horizontal blanking flag, aligned with data_in; 0 for active words.
- data_out  out  10  descrambled BT.656 word, registered.

Behaviour:
- Reset (async, reset_n=0):
  - data_out=10'h000; write/read counters=0; write buffer select=0.
  - Both buffer valid flags=0; latched cuts=0; vblank tags=0.
  - Buffer RAM contents are not cleared.
- Write side:
  - While H=0, data_in is written to the write buffer at address wr_cnt, then wr_cnt increments.
  - Words with wr_cnt ≥ ACTIVE_LEN are dropped, with no wrap.
  - On the H 1→0 edge (first active word): latch cut = raw_cut_position*CUT_STEP and tag = V into the write buffer's side registers. This word is written at address 0.
  - On the H 0→1 edge (end of active): mark the write buffer valid, toggle the buffer select, clear wr_cnt.
  - A short line still swaps buffers; unwritten addresses hold stale data.
- Read side, from the buffer just completed:
  - On the H 1→0 edge, the read counter starts at rd_start. rd_start is 0 if tag=1 (V-blank line, unrotated) or cut=0; otherwise ACTIVE_LEN−cut.
  - The read counter increments per active word and wraps ACTIVE_LEN−1→0.
  - Net result: out[k] = scr[(k − cut) mod ACTIVE_LEN], the inverse of the rotator.
- Output mux, registered for 1 cycle:
  - H=1: data_out = data_in delayed 1 cycle. EAV/SAV and blanking are unchanged.
  - H=0 and read buffer valid: data_out = RAM word read at the counter. RAM read latency is absorbed so the total data latency is 1 cycle relative to the active-word slot.
  - H=0 and buffer not valid (first line after reset): black. Even active index → 10'h200, odd → 10'h040.
  - H=0 beyond ACTIVE_LEN words: black.
- Simultaneous events: the buffer swap on the H 0→1 edge happens before any read of the new line. Reading uses the buffer written last line, never the one being written.
- Reset mid-line: everything returns to the reset state. The next full line is buffered and the following line outputs it.

Optional Feature:
- Macro LINE_DEROTATOR_LEN_ERR_EN.
- When defined:
  - Adds output port len_err (1 bit).
  - len_err is a one-cycle pulse on the H 0→1 edge when the line's active word count ≠ ACTIVE_LEN. Counting saturates at ACTIVE_LEN+1.
  - Reset value of len_err is 0.
- When undefined: the port and counter logic are absent and the rest of the behaviour is identical.

Test Plan:
- Ramp line, cut raw=0: active words 0..1439 → next line outputs 0..1439 unchanged; EAV/SAV appear 1 cycle late and unchanged.
- Scrambled line with raw=128 (cut=512), scr[k]=(k+512) mod 1440 → next line out[k]=k for all k; word 0 out=0, word 928 out=928.
- Line with V=1, raw=200, ramp data → next line output equals input ramp order (no derotation).
- First line after reset_n release → active region outputs 10'h200,10'h040 alternating; blanking words pass through.
- Short line (1000 active words) with LINE_DEROTATOR_LEN_ERR_EN → len_err=1 for one cycle at H rise; a 1440-word line gives no pulse.
- reset_n pulsed low at active word 700 → data_out=0 during reset; the line after the next full line is correct.
- Round-trip: line_rotator→line_derotator over 10 frames with random raw cut (seed 42) → output equals source, delayed by 2 lines.

Source files
------------

// File: rtl/line_derotator.sv
// line_derotator: undoes the per-line cyclic rotation applied by line_rotator.
// Active words of one line are captured into one half of a ping-pong buffer
// while the other half (the line captured before) is read back starting at
// the inverse rotation offset, so active video has one line of latency and
// timing reference / blanking words pass through with one cycle of latency.
// Optional feature: define LINE_DEROTATOR_LEN_ERR_EN to add the len_err
// output, a one-cycle pulse when a line's active word count is not ACTIVE_LEN.
module line_derotator #(
  parameter int ACTIVE_LEN = 1440,
  parameter int CUT_STEP   = 4,
  parameter int ADDR_W     = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  data_in,
  input  logic [7:0]  raw_cut_position,
  input  logic        V,
  input  logic        H,
`ifdef LINE_DEROTATOR_LEN_ERR_EN
  output logic        len_err,
`endif
  output logic [9:0]  data_out
);

  localparam logic [ADDR_W-1:0] LEN       = ADDR_W'(ACTIVE_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ACTIVE_LEN - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [9:0]        BLACK_C   = 10'h200;
  localparam logic [9:0]        BLACK_Y   = 10'h040;

  logic [9:0]              mem_q [0:1][0:ACTIVE_LEN-1];

  logic                    h_q;
  logic                    wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]       rd_cnt_q, rd_cnt_d;
  logic [1:0]              valid_q, valid_d;
  logic [1:0][ADDR_W-1:0]  cut_q, cut_d;
  logic [1:0]              tag_q, tag_d;
  logic [9:0]              data_out_q, data_out_d;

  logic                    h_fall, h_rise;
  logic                    rd_sel;
  logic                    wr_in_range;
  logic [ADDR_W-1:0]       cut_new;
  logic [ADDR_W-1:0]       rd_start;
  logic [ADDR_W-1:0]       rd_addr;
  logic [9:0]              black_word;

  assign h_fall      = h_q & ~H;
  assign h_rise      = ~h_q & H;
  assign rd_sel      = ~wr_sel_q;
  assign wr_in_range = (wr_cnt_q < LEN);
  assign cut_new     = ADDR_W'(raw_cut_position) * ADDR_W'(CUT_STEP);
  // V-blank lines and zero cuts were never rotated, so read them in order.
  assign rd_start    = (tag_q[rd_sel] || (cut_q[rd_sel] == '0)) ? '0 : (LEN - cut_q[rd_sel]);
  // The first active word must already use the start offset, not the stale counter.
  assign rd_addr     = h_fall ? rd_start : rd_cnt_q;
  assign black_word  = wr_cnt_q[0] ? BLACK_Y : BLACK_C;

  // Capture active words into the half currently being written; RAM is not reset.
  always_ff @(posedge clk) begin
    if (!H && wr_in_range) begin
      mem_q[wr_sel_q][wr_cnt_q] <= data_in;
    end
  end

  // Next-state for counters, buffer bookkeeping and the output word.
  always_comb begin
    wr_sel_d   = wr_sel_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    valid_d    = valid_q;
    cut_d      = cut_q;
    tag_d      = tag_q;
    data_out_d = data_in;
    if (!H) begin
      wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : (wr_cnt_q + ONE);
      rd_cnt_d = (rd_addr == LAST_ADDR) ? '0 : (rd_addr + ONE);
      if (!wr_in_range) begin
        data_out_d = black_word;
      end else if (valid_q[rd_sel]) begin
        data_out_d = mem_q[rd_sel][rd_addr];
      end else begin
        data_out_d = black_word;
      end
    end
    if (h_fall) begin
      cut_d[wr_sel_q] = cut_new;
      tag_d[wr_sel_q] = V;
    end
    if (h_rise) begin
      valid_d[wr_sel_q] = 1'b1;
      wr_sel_d          = ~wr_sel_q;
      wr_cnt_d          = '0;
    end
  end

  // State registers; h_q resets high so a reset during blanking is not an end of line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q        <= 1'b1;
      wr_sel_q   <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      valid_q    <= '0;
      cut_q      <= '0;
      tag_q      <= '0;
      data_out_q <= 10'h000;
    end else begin
      h_q        <= H;
      wr_sel_q   <= wr_sel_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      valid_q    <= valid_d;
      cut_q      <= cut_d;
      tag_q      <= tag_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

`ifdef LINE_DEROTATOR_LEN_ERR_EN
  localparam logic [ADDR_W-1:0] LEN_SAT = ADDR_W'(ACTIVE_LEN + 1);

  logic [ADDR_W-1:0] len_cnt_q;
  logic              len_err_q;

  // Count active words per line (saturating) and flag a wrong count at end of active.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= h_rise && (len_cnt_q != LEN);
      if (h_rise) begin
        len_cnt_q <= '0;
      end else if (!H && (len_cnt_q != LEN_SAT)) begin
        len_cnt_q <= len_cnt_q + ONE;
      end
    end
  end

  assign len_err = len_err_q;
`endif

endmodule

// File: tb/tb_line_derotator.sv
// Bench for line_derotator: whole lines are generated by a rotator-style
// scrambler, a line-level model predicts every output word, and source lines
// give literal expectations for the derotated output.
module tb_line_derotator;

  localparam int L = 1440;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] data_in = 10'h000;
  logic [7:0] raw_cut_position = 8'h00;
  logic       V = 1'b0;
  logic       H = 1'b1;
  logic [9:0] data_out;
`ifdef LINE_DEROTATOR_LEN_ERR_EN
  logic       len_err;
`endif

  always #5 clk = ~clk;

  line_derotator dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .data_in          (data_in),
    .raw_cut_position (raw_cut_position),
    .V                (V),
    .H                (H),
`ifdef LINE_DEROTATOR_LEN_ERR_EN
    .len_err          (len_err),
`endif
    .data_out         (data_out)
  );

  typedef struct {
    logic [9:0] exp;
    bit         chk;
    string      name;
    bit         lit_en;
    logic [9:0] lit;
    logic       le;
  } exp_t;

  exp_t q[$];
  exp_t ce;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Line-level model of the two line stores.
  logic [9:0] mbuf [2][L];
  bit         mvalid [2];
  int         mcut [2];
  bit         mtag [2];
  int         wsel;
  int         prev_n;

  logic [9:0] line_d [L+8];
  logic [9:0] src_d [L];
  logic [9:0] ref_d [L];
  bit         ref_en;

  function automatic logic [9:0] blk(input int k);
    return (k % 2 == 1) ? 10'h040 : 10'h200;
  endfunction

  function automatic exp_t mk(input logic [9:0] exp, input bit chk, input string name,
                              input bit lit_en, input logic [9:0] lit, input logic le);
    exp_t e;
    e.exp = exp; e.chk = chk; e.name = name; e.lit_en = lit_en; e.lit = lit; e.le = le;
    return e;
  endfunction

  task automatic drive(input logic [9:0] d, input logic h, input logic v,
                       input logic [7:0] raw, input logic rstn, input exp_t e);
    @(negedge clk);
    data_in = d; H = h; V = v; raw_cut_position = raw; reset_n = rstn;
    q.push_back(e);
  endtask

  task automatic model_reset();
    mvalid[0] = 0; mvalid[1] = 0;
    mcut[0] = 0; mcut[1] = 0;
    mtag[0] = 0; mtag[1] = 0;
    wsel = 0;
    prev_n = -1;
  endtask

  // One line: 16 blanking words (EAV, blanking, SAV) then n active words from line_d.
  // rst_at >= 0 pulses reset for three active words starting at that index.
  task automatic send_line(input int n, input bit v, input int raw, input bit chk, input int rst_at);
    int rsel, addr, start, cnt;
    logic [9:0] w, ex, eav, sav;
    logic [7:0] raw8;
    logic le;
    raw8 = raw[7:0];
    eav = v ? 10'h2D8 : 10'h274;
    sav = v ? 10'h2AC : 10'h200;
    rsel = wsel ^ 1;
    for (int i = 0; i < 16; i++) begin
      case (i)
        0, 12:     w = 10'h3FF;
        1, 2, 13, 14: w = 10'h000;
        3:         w = eav;
        15:        w = sav;
        default:   w = blk(i);
      endcase
      le = (i == 0) && (prev_n >= 0) && (prev_n != L);
      drive(w, 1'b1, v, raw8, 1'b1, mk(w, chk, "blank", 0, 10'h000, le));
    end
    prev_n = -1;
    start = 0;
    for (int k = 0; k < n; k++) begin
      if (rst_at >= 0 && k >= rst_at && k < rst_at + 3) begin
        if (k == rst_at) model_reset();
        drive(line_d[k], 1'b0, v, raw8, 1'b0, mk(10'h000, 1, "reset", 0, 10'h000, 1'b0));
        start = rst_at + 3;
      end else if (rst_at >= 0 && k >= rst_at + 3) begin
        drive(line_d[k], 1'b0, v, raw8, 1'b1, mk(10'h000, 0, "post_reset", 0, 10'h000, 1'b0));
      end else begin
        if (k >= L || !mvalid[rsel]) begin
          ex = blk(k);
        end else begin
          addr = (mtag[rsel] || mcut[rsel] == 0) ? k : (k - mcut[rsel] + L) % L;
          ex = mbuf[rsel][addr];
        end
        drive(line_d[k], 1'b0, v, raw8, 1'b1,
              mk(ex, chk, "active", chk && ref_en && (k < L), (k < L) ? ref_d[k] : 10'h000, 1'b0));
      end
    end
    if (n > 0) begin
      cnt = n - start;
      mcut[wsel] = raw * 4;
      mtag[wsel] = v;
      for (int k = 0; k < cnt && k < L; k++) mbuf[wsel][k] = line_d[start + k];
      mvalid[wsel] = 1;
      wsel ^= 1;
      prev_n = cnt;
    end
  endtask

  // Rotator-style line: src is the picture, line_d is what the rotator would emit.
  task automatic rt_line(input bit ramp, input int raw, input bit v, input int n, input bit chk);
    int cut;
    cut = raw * 4;
    for (int k = 0; k < L; k++) src_d[k] = ramp ? 10'(k) : 10'($urandom);
    for (int k = 0; k < n; k++)
      line_d[k] = (k >= L) ? 10'($urandom) : (v ? src_d[k] : src_d[(k + cut) % L]);
    send_line(n, v, raw, chk, -1);
    for (int k = 0; k < L; k++) ref_d[k] = src_d[k];
    ref_en = (n == L);
  endtask

  // Compare process: one expectation per clock, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() > 0) begin
      ce = q.pop_front();
      if (ce.chk) begin
        total++;
        if (data_out !== ce.exp) begin
          bad++;
          $display("FAIL %s cyc=%0d data_out=%h model=%h", ce.name, cyc, data_out, ce.exp);
        end
`ifdef LINE_DEROTATOR_LEN_ERR_EN
        total++;
        if (len_err !== ce.le) begin
          bad++;
          $display("FAIL len_err cyc=%0d got=%b exp=%b", cyc, len_err, ce.le);
        end
`endif
      end
      if (ce.lit_en) begin
        total++;
        if (data_out !== ce.lit) begin
          bad++;
          $display("FAIL source_word cyc=%0d data_out=%h source=%h", cyc, data_out, ce.lit);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d queue=%0d", cyc, q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 4; i++)
      drive(10'h000, 1'b1, 1'b0, 8'h00, 1'b0, mk(10'h000, 1, "reset", 0, 10'h000, 1'b0));

    // First line after reset shows black; literal pattern pins the model.
    for (int k = 0; k < L; k++) ref_d[k] = blk(k);
    ref_en = 1;
    rt_line(1, 0, 0, L, 1);
    rt_line(1, 128, 0, L, 1);     // outputs the unscrambled ramp
    rt_line(1, 200, 1, L, 1);     // outputs ramp derotated by 512
    rt_line(0, int'($urandom_range(1, 255)), 0, L, 1); // outputs V-blank ramp in order
    for (int i = 0; i < 6; i++)
      rt_line(0, int'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), L, 1);

    rt_line(0, int'($urandom_range(1, 255)), 0, 1000, 1);  // short line
    rt_line(0, int'($urandom_range(1, 255)), 0, L, 1);     // reads short buffer (stale tail)
    rt_line(0, int'($urandom_range(1, 255)), 0, L + 2, 1); // long line, black past end
    rt_line(0, int'($urandom_range(1, 255)), 0, L, 1);
    rt_line(0, 255, 0, L, 1);

    // Reset in the middle of an active region.
    for (int k = 0; k < L; k++) line_d[k] = 10'($urandom);
    send_line(L, 0, 77, 1, 700);
    ref_en = 0;
    rt_line(0, int'($urandom_range(1, 255)), 0, L, 0);
    rt_line(0, int'($urandom_range(1, 255)), 0, L, 1);
    rt_line(0, int'($urandom_range(1, 255)), 1, L, 1);
    send_line(0, 0, 0, 1, -1);

    repeat (3) @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
